// File: rtl/pcs_tx_idle_elastic.sv
// TX-domain elastic FIFO between loopback retiming and the TX PCS encoder: deletes idles when
// occupancy is high, inserts idles when empty. Optional idle statistics under PCS_ELASTIC_STATS_EN.
module pcs_tx_idle_elastic #(
    parameter int DATA_W      = 64,
    parameter int LANE0_CNT_N = 1,
    parameter int DEPTH       = 8,
    parameter int HI_THRESH   = 6,
    localparam int KEEP_W     = DATA_W / 8
) (
    input  logic                     tx_clk,
    input  logic                     tx_reset,
    input  logic                     pcs_rx_valid_i,
    input  logic                     pcs_rx_ctrl_i,
    input  logic                     pcs_rx_idle_i,
    input  logic                     pcs_rx_term_i,
    input  logic                     pcs_rx_err_i,
    input  logic [LANE0_CNT_N-1:0]   pcs_rx_start_i,
    input  logic [DATA_W-1:0]        pcs_rx_data_i,
    input  logic [KEEP_W-1:0]        pcs_rx_keep_i,
    input  logic                     pcs_tx_ready_i,
    output logic                     pcs_tx_ctrl_o,
    output logic                     pcs_tx_idle_o,
    output logic                     pcs_tx_term_o,
    output logic                     pcs_tx_err_o,
    output logic [LANE0_CNT_N-1:0]   pcs_tx_start_o,
    output logic [DATA_W-1:0]        pcs_tx_data_o,
    output logic [KEEP_W-1:0]        pcs_tx_keep_o,
`ifdef PCS_ELASTIC_STATS_EN
    output logic [15:0]              ins_cnt_o,
    output logic [15:0]              del_cnt_o,
`endif
    output logic                     underflow_o,
    output logic                     overflow_o,
    output logic                     dbg_state,
    output logic [$clog2(DEPTH):0]   dbg_occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] HI_OCC    = OCC_W'(HI_THRESH);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    typedef struct packed {
        logic                   ctrl;
        logic                   idle;
        logic                   term;
        logic                   err;
        logic [LANE0_CNT_N-1:0] start;
        logic [DATA_W-1:0]      data;
        logic [KEEP_W-1:0]      keep;
    } blk_t;

    localparam int BLK_W = $bits(blk_t);
    localparam blk_t IDLE_BLK = blk_t'({1'b1, 1'b1, 1'b0, 1'b0, {(BLK_W-4){1'b0}}});
    localparam blk_t ERR_BLK  = blk_t'({1'b1, 1'b0, 1'b0, 1'b1, {(BLK_W-4){1'b0}}});

    typedef enum logic {IDLE_S = 1'b0, FRAME_S = 1'b1} state_t;

    // Handshake: a block enters when pcs_rx_valid_i=1 on an edge (no backpressure, so it is
    // written, deleted or dropped); the output block is consumed on every edge with pcs_tx_ready_i=1.
    blk_t             mem [DEPTH];
    blk_t             in_blk;
    blk_t             out_q;
    blk_t             load_blk;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    state_t           state_q;
    state_t           state_d;
    state_t           state_mid;
    logic             empty;
    logic             pop;
    logic             del;
    logic             wr;
    logic             drop;
    logic             ins;
    logic             under;
    logic             underflow_q;
    logic             overflow_q;

    assign in_blk = '{ctrl: pcs_rx_ctrl_i, idle: pcs_rx_idle_i, term: pcs_rx_term_i,
                      err: pcs_rx_err_i, start: pcs_rx_start_i, data: pcs_rx_data_i,
                      keep: pcs_rx_keep_i};

    always_comb begin
        empty    = (occ == '0);
        pop      = pcs_tx_ready_i && !empty;
        del      = pcs_rx_valid_i && pcs_rx_idle_i && (occ >= HI_OCC);
        // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
        wr       = pcs_rx_valid_i && !del && ((occ < DEPTH_OCC) || pop);
        drop     = pcs_rx_valid_i && !del && !wr;
        ins      = pcs_tx_ready_i && empty && (state_q == IDLE_S);
        under    = pcs_tx_ready_i && empty && (state_q == FRAME_S);
        load_blk = IDLE_BLK;
        if (pop) begin
            load_blk = mem[rd_ptr];
        end else if (under) begin
            load_blk = ERR_BLK;
        end
    end

    // Term/err closes the frame before start opens one, so term+start leaves the FSM in FRAME_S.
    always_comb begin
        state_mid = state_q;
        state_d   = state_q;
        if (pcs_tx_ready_i) begin
            if (load_blk.term || load_blk.err) begin
                state_mid = IDLE_S;
            end
            state_d = (load_blk.start != '0) ? FRAME_S : state_mid;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            state_q <= IDLE_S;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (!tx_reset && wr) begin
            mem[wr_ptr] <= in_blk;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            out_q       <= IDLE_BLK;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (pop && !wr) begin
                occ <= occ - OCC_W'(1);
            end
            if (pcs_tx_ready_i) begin
                out_q <= load_blk;
            end
            if (under) begin
                underflow_q <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef PCS_ELASTIC_STATS_EN
    logic [15:0] ins_cnt_q;
    logic [15:0] del_cnt_q;

    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            ins_cnt_q <= '0;
            del_cnt_q <= '0;
        end else begin
            if (ins && (ins_cnt_q != 16'hFFFF)) begin
                ins_cnt_q <= ins_cnt_q + 16'd1;
            end
            if (del && (del_cnt_q != 16'hFFFF)) begin
                del_cnt_q <= del_cnt_q + 16'd1;
            end
        end
    end

    assign ins_cnt_o = ins_cnt_q;
    assign del_cnt_o = del_cnt_q;
`else
    logic unused_ins;
    assign unused_ins = ins;
`endif

    assign pcs_tx_ctrl_o  = out_q.ctrl;
    assign pcs_tx_idle_o  = out_q.idle;
    assign pcs_tx_term_o  = out_q.term;
    assign pcs_tx_err_o   = out_q.err;
    assign pcs_tx_start_o = out_q.start;
    assign pcs_tx_data_o  = out_q.data;
    assign pcs_tx_keep_o  = out_q.keep;
    assign underflow_o    = underflow_q;
    assign overflow_o     = overflow_q;
    assign dbg_state      = (state_q == FRAME_S);
    assign dbg_occupancy  = occ;

endmodule

// File: tb/tb_pcs_tx_idle_elastic.sv
// Directed bench for pcs_tx_idle_elastic; stats checks compile in with PCS_ELASTIC_STATS_EN.
module tb_pcs_tx_idle_elastic;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int BW     = 4 + 1 + DATA_W + KEEP_W;

    logic              clk = 1'b0;
    logic              tx_reset = 1'b1;
    logic              valid = 1'b0;
    logic              in_ctrl = 1'b0, in_idle = 1'b0, in_term = 1'b0, in_err = 1'b0;
    logic [0:0]        in_start = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [KEEP_W-1:0] in_keep = '0;
    logic              ready = 1'b0;
    logic              tx_ctrl, tx_idle, tx_term, tx_err;
    logic [0:0]        tx_start;
    logic [DATA_W-1:0] tx_data;
    logic [KEEP_W-1:0] tx_keep;
    logic              underflow, overflow, dbg_state;
    logic [3:0]        dbg_occ;
`ifdef PCS_ELASTIC_STATS_EN
    logic [15:0]       ins_cnt, del_cnt;
`endif
    logic [BW-1:0]     out_blk;

    int n_cmp = 0;
    int n_err = 0;

    pcs_tx_idle_elastic dut (
        .tx_clk(clk), .tx_reset(tx_reset), .pcs_rx_valid_i(valid),
        .pcs_rx_ctrl_i(in_ctrl), .pcs_rx_idle_i(in_idle), .pcs_rx_term_i(in_term),
        .pcs_rx_err_i(in_err), .pcs_rx_start_i(in_start), .pcs_rx_data_i(in_data),
        .pcs_rx_keep_i(in_keep), .pcs_tx_ready_i(ready),
        .pcs_tx_ctrl_o(tx_ctrl), .pcs_tx_idle_o(tx_idle), .pcs_tx_term_o(tx_term),
        .pcs_tx_err_o(tx_err), .pcs_tx_start_o(tx_start), .pcs_tx_data_o(tx_data),
        .pcs_tx_keep_o(tx_keep),
`ifdef PCS_ELASTIC_STATS_EN
        .ins_cnt_o(ins_cnt), .del_cnt_o(del_cnt),
`endif
        .underflow_o(underflow), .overflow_o(overflow),
        .dbg_state(dbg_state), .dbg_occupancy(dbg_occ)
    );

    assign out_blk = {tx_ctrl, tx_idle, tx_term, tx_err, tx_start, tx_data, tx_keep};

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk(input logic c, input logic i, input logic t,
                                         input logic e, input logic s,
                                         input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k);
        return {c, i, t, e, s, d, k};
    endfunction

    function automatic logic [BW-1:0] idle_blk();
        return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    endfunction

    function automatic logic [BW-1:0] err_blk();
        return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    endfunction

    function automatic logic [BW-1:0] data_blk(input int n);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hDA7A_0000_0000_0000 | 64'(n), 8'hFF);
    endfunction

    function automatic logic [BW-1:0] start_blk();
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hD555_5555_5555_55FB, 8'hFF);
    endfunction

    function automatic logic [BW-1:0] term_blk();
        return mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0708_09FD, 8'h07);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [BW-1:0] b);
        valid = v;
        {in_ctrl, in_idle, in_term, in_err, in_start, in_data, in_keep} = b;
    endtask

    task automatic do_reset();
        tx_reset = 1'b1;
        ready = 1'b1;
        drive(1'b0, idle_blk());
        tick();
        tick();
        tx_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (out_blk !== idle_blk()) begin
            n_err++; $display("FAIL reset_out got %h want %h", out_blk, idle_blk());
        end
        n_cmp++;
        if ({underflow, overflow, dbg_state, dbg_occ} !== 7'd0) begin
            n_err++; $display("FAIL reset_state got uf=%b of=%b st=%b occ=%0d want 0", underflow, overflow, dbg_state, dbg_occ);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (out_blk !== idle_blk()) begin
                n_err++; $display("FAIL reset_idle_%0d got %h want %h", i, out_blk, idle_blk());
            end
        end
        n_cmp++;
        if ({underflow, overflow} !== 2'b00) begin
            n_err++; $display("FAIL reset_sticky got %b want 00", {underflow, overflow});
        end
`ifdef PCS_ELASTIC_STATS_EN
        n_cmp++;
        if (ins_cnt !== 16'd10) begin
            n_err++; $display("FAIL reset_ins_cnt got %0d want 10", ins_cnt);
        end
`endif
    endtask

    task automatic test_frame();
        logic [BW-1:0] fr [8];
        logic [BW-1:0] exp_b;
        fr[0] = start_blk();
        for (int i = 1; i < 7; i++) fr[i] = data_blk(i);
        fr[7] = term_blk();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            if (k < 8) drive(1'b1, fr[k]);
            else drive(1'b0, idle_blk());
            tick();
            exp_b = (k == 0) ? idle_blk() : fr[k-1];
            n_cmp++;
            if (out_blk !== exp_b) begin
                n_err++; $display("FAIL frame_out_%0d got %h want %h", k, out_blk, exp_b);
            end
            if (k == 1) begin
                n_cmp++;
                if (dbg_state !== 1'b1) begin
                    n_err++; $display("FAIL frame_state_open got %b want 1", dbg_state);
                end
            end
        end
        n_cmp++;
        if (dbg_state !== 1'b0) begin
            n_err++; $display("FAIL frame_state_closed got %b want 0", dbg_state);
        end
        tick();
        n_cmp++;
        if (out_blk !== idle_blk() || underflow !== 1'b0) begin
            n_err++; $display("FAIL frame_after got %h uf=%b want idle uf=0", out_blk, underflow);
        end
    endtask

    task automatic test_delete();
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, data_blk(i));
            tick();
        end
        drive(1'b1, idle_blk());
        tick();
        n_cmp++;
        if (dbg_occ !== 4'd6) begin
            n_err++; $display("FAIL delete_fill got %0d want 6", dbg_occ);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, idle_blk());
            tick();
            n_cmp++;
            if (dbg_occ !== 4'd6) begin
                n_err++; $display("FAIL delete_occ_%0d got %0d want 6", i, dbg_occ);
            end
        end
`ifdef PCS_ELASTIC_STATS_EN
        n_cmp++;
        if (del_cnt !== 16'd4) begin
            n_err++; $display("FAIL delete_cnt got %0d want 4", del_cnt);
        end
`endif
        drive(1'b0, idle_blk());
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (out_blk !== data_blk(i)) begin
                n_err++; $display("FAIL delete_drain_%0d got %h want %h", i, out_blk, data_blk(i));
            end
        end
        tick();
        tick();
        n_cmp++;
        if (out_blk !== idle_blk() || dbg_occ !== 4'd0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL delete_end got %h occ=%0d of=%b want idle occ=0 of=0", out_blk, dbg_occ, overflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(1'b1, start_blk());
        tick();
        n_cmp++;
        if (out_blk !== idle_blk()) begin
            n_err++; $display("FAIL under_first got %h want %h", out_blk, idle_blk());
        end
        drive(1'b0, idle_blk());
        tick();
        n_cmp++;
        if (out_blk !== start_blk() || dbg_state !== 1'b1) begin
            n_err++; $display("FAIL under_start got %h st=%b want %h st=1", out_blk, dbg_state, start_blk());
        end
        tick();
        n_cmp++;
        if (out_blk !== err_blk() || underflow !== 1'b1 || dbg_state !== 1'b0) begin
            n_err++; $display("FAIL under_err got %h uf=%b st=%b want %h uf=1 st=0", out_blk, underflow, dbg_state, err_blk());
        end
        tick();
        n_cmp++;
        if (out_blk !== idle_blk() || underflow !== 1'b1 || overflow !== 1'b0) begin
            n_err++; $display("FAIL under_after got %h uf=%b of=%b want idle uf=1 of=0", out_blk, underflow, overflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, data_blk(i));
            tick();
        end
        n_cmp++;
        if (dbg_occ !== 4'd8 || overflow !== 1'b0) begin
            n_err++; $display("FAIL over_full got occ=%0d of=%b want occ=8 of=0", dbg_occ, overflow);
        end
        drive(1'b1, data_blk(8));
        tick();
        n_cmp++;
        if (dbg_occ !== 4'd8 || overflow !== 1'b1) begin
            n_err++; $display("FAIL over_drop got occ=%0d of=%b want occ=8 of=1", dbg_occ, overflow);
        end
        ready = 1'b1;
        drive(1'b1, data_blk(9));
        tick();
        n_cmp++;
        if (out_blk !== data_blk(0) || dbg_occ !== 4'd8) begin
            n_err++; $display("FAIL over_pushpop got %h occ=%0d want %h occ=8", out_blk, dbg_occ, data_blk(0));
        end
        drive(1'b0, idle_blk());
        for (int i = 1; i < 8; i++) begin
            tick();
            n_cmp++;
            if (out_blk !== data_blk(i)) begin
                n_err++; $display("FAIL over_drain_%0d got %h want %h", i, out_blk, data_blk(i));
            end
        end
        tick();
        n_cmp++;
        if (out_blk !== data_blk(9)) begin
            n_err++; $display("FAIL over_last got %h want %h", out_blk, data_blk(9));
        end
        tick();
        n_cmp++;
        if (out_blk !== idle_blk() || overflow !== 1'b1 || underflow !== 1'b0) begin
            n_err++; $display("FAIL over_end got %h of=%b uf=%b want idle of=1 uf=0", out_blk, overflow, underflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        drive(1'b1, start_blk());
        tick();
        drive(1'b1, data_blk(1));
        tick();
        n_cmp++;
        if (out_blk !== start_blk() || dbg_state !== 1'b1 || dbg_occ !== 4'd1) begin
            n_err++; $display("FAIL mid_open got %h st=%b occ=%0d want start st=1 occ=1", out_blk, dbg_state, dbg_occ);
        end
        ready = 1'b0;
        for (int i = 2; i < 6; i++) begin
            drive(1'b1, data_blk(i));
            tick();
        end
        n_cmp++;
        if (dbg_occ !== 4'd5) begin
            n_err++; $display("FAIL mid_occ got %0d want 5", dbg_occ);
        end
        drive(1'b0, idle_blk());
        tx_reset = 1'b1;
        tick();
        n_cmp++;
        if (out_blk !== idle_blk() || dbg_occ !== 4'd0 || dbg_state !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got %h occ=%0d st=%b want idle occ=0 st=0", out_blk, dbg_occ, dbg_state);
        end
        tx_reset = 1'b0;
        ready = 1'b1;
        tick();
        n_cmp++;
        if (out_blk !== idle_blk() || dbg_occ !== 4'd0) begin
            n_err++; $display("FAIL mid_flushed got %h occ=%0d want idle occ=0", out_blk, dbg_occ);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_delete();
        test_underflow();
        test_overflow();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
